// File: rtl/mips_writeback_stage.sv
// MIPS writeback stage: retires ALU results into a 32x32 GPR file plus HI/LO, with a one-entry retire record.
// Optional WB_STATS_EN adds retired/overflow counters.
module mips_writeback_stage #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_c,
  input  logic [2:0]      in_zon,
  input  logic [XLEN-1:0] in_hi,
  input  logic [XLEN-1:0] in_lo,
  input  logic [4:0]      rs_addr,
  output logic [XLEN-1:0] rs_data,
  input  logic [4:0]      rt_addr,
  output logic [XLEN-1:0] rt_data,
  output logic [XLEN-1:0] hi_q,
  output logic [XLEN-1:0] lo_q,
  output logic            ret_valid,
  input  logic            ret_ready,
  output logic            ret_we,
  output logic [4:0]      ret_rd,
  output logic [XLEN-1:0] ret_data,
  output logic            ret_ovf
`ifdef WB_STATS_EN
  ,
  output logic [31:0]     stat_retired,
  output logic [15:0]     stat_ovf
`endif
);

  typedef struct packed {
    logic            gpr_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
    logic            hi_we;
    logic [XLEN-1:0] hi_d;
    logic            lo_we;
    logic [XLEN-1:0] lo_d;
    logic            ovf;
  } dec_t;

  logic [NREG-1:0][XLEN-1:0] gpr;
  dec_t dec;
  logic xfer, wr_en;
  logic [5:0] opcode, func;

  assign opcode   = in_instr[31:26];
  assign func     = in_instr[5:0];
  assign in_ready = !ret_valid || ret_ready;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    dec   = '0;
    wr_en = 1'b0;
    if (opcode == 6'h00) begin
      case (func)
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23,
        6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
          wr_en = 1'b1; dec.rd = in_instr[15:11]; dec.wdata = in_c;
        end
        6'h20, 6'h22: begin
          dec.ovf = in_zon[1];
          wr_en = !in_zon[1]; dec.rd = in_instr[15:11]; dec.wdata = in_c;
        end
        6'h10: begin wr_en = 1'b1; dec.rd = in_instr[15:11]; dec.wdata = hi_q; end
        6'h12: begin wr_en = 1'b1; dec.rd = in_instr[15:11]; dec.wdata = lo_q; end
        6'h11: begin dec.hi_we = 1'b1; dec.hi_d = in_c; end
        6'h13: begin dec.lo_we = 1'b1; dec.lo_d = in_c; end
        6'h18, 6'h19, 6'h1a, 6'h1b: begin
          dec.hi_we = 1'b1; dec.hi_d = in_hi;
          dec.lo_we = 1'b1; dec.lo_d = in_lo;
        end
        default: ;
      endcase
    end else begin
      case (opcode)
        6'h08: begin
          dec.ovf = in_zon[1];
          wr_en = !in_zon[1]; dec.rd = in_instr[20:16]; dec.wdata = in_c;
        end
        6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin
          wr_en = 1'b1; dec.rd = in_instr[20:16]; dec.wdata = in_c;
        end
        default: ;
      endcase
    end
    // r0 is never a destination; the record then reports rd=0, we=0
    dec.gpr_we = wr_en && (dec.rd != 5'd0);
    if (!dec.gpr_we) begin
      dec.rd    = 5'd0;
      dec.wdata = '0;
    end
  end

  // Two read ports with write-first bypass from the retiring result
  logic [1:0][4:0]      rd_addr;
  logic [1:0][XLEN-1:0] rd_data;
  assign rd_addr = {rt_addr, rs_addr};
  for (genvar p = 0; p < 2; p++) begin : g_rd
    assign rd_data[p] = (rd_addr[p] == 5'd0) ? '0 :
                        (xfer && dec.gpr_we && dec.rd == rd_addr[p]) ? dec.wdata :
                        gpr[rd_addr[p]];
  end
  assign rs_data = rd_data[0];
  assign rt_data = rd_data[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (xfer) begin
      if (dec.gpr_we) gpr[dec.rd] <= dec.wdata;
      if (dec.hi_we)  hi_q <= dec.hi_d;
      if (dec.lo_we)  lo_q <= dec.lo_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_valid <= 1'b0;
      ret_we    <= 1'b0;
      ret_rd    <= '0;
      ret_data  <= '0;
      ret_ovf   <= 1'b0;
    end else if (xfer) begin
      ret_valid <= 1'b1;
      ret_we    <= dec.gpr_we;
      ret_rd    <= dec.rd;
      ret_data  <= dec.wdata;
      ret_ovf   <= dec.ovf;
    end else if (ret_ready) begin
      ret_valid <= 1'b0;
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_retired <= '0;
      stat_ovf     <= '0;
    end else if (xfer) begin
      stat_retired <= stat_retired + 32'd1;
      if (dec.ovf && stat_ovf != 16'hFFFF) stat_ovf <= stat_ovf + 16'd1;
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{in_instr[25:21], in_instr[10:6], in_zon[2], in_zon[0]};

endmodule

// File: tb/tb_mips_writeback_stage.sv
// Randomized bench for mips_writeback_stage against an array-based architectural model, plus directed pins.
module tb_mips_writeback_stage;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        in_valid = 1'b0, ret_ready = 1'b0;
  logic [31:0] in_instr = '0, in_c = '0, in_hi = '0, in_lo = '0;
  logic [2:0]  in_zon = '0;
  logic [4:0]  rs_addr = '0, rt_addr = '0;
  logic        in_ready, ret_valid, ret_we, ret_ovf;
  logic [31:0] rs_data, rt_data, hi_q, lo_q, ret_data;
  logic [4:0]  ret_rd;

  int n_chk = 0, n_fail = 0;
  logic cmp_en = 1'b0;

  mips_writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_c(in_c), .in_zon(in_zon), .in_hi(in_hi), .in_lo(in_lo),
    .rs_addr(rs_addr), .rs_data(rs_data), .rt_addr(rt_addr), .rt_data(rt_data),
    .hi_q(hi_q), .lo_q(lo_q), .ret_valid(ret_valid), .ret_ready(ret_ready),
    .ret_we(ret_we), .ret_rd(ret_rd), .ret_data(ret_data), .ret_ovf(ret_ovf));

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Architectural model: what retiring one instruction does to the machine
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo, m_data;
  logic        m_rv, m_we, m_ovf;
  logic [4:0]  m_rd;
  logic        m_ready;
  assign m_ready = !m_rv || ret_ready;

  function automatic void mdec(input logic [31:0] ins, c, input logic [2:0] zon,
                               input logic [31:0] ih, il, ch, cl,
                               output logic we, output logic [4:0] d, output logic [31:0] v,
                               output logic hwe, output logic [31:0] hv,
                               output logic lwe, output logic [31:0] lv, output logic ovf);
    logic [5:0] op, fn;
    op = ins[31:26]; fn = ins[5:0];
    we = 0; d = 0; v = 0; hwe = 0; hv = 0; lwe = 0; lv = 0; ovf = 0;
    if (op == 6'h00) begin
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2a, 6'h2b}) begin
        we = 1; d = ins[15:11]; v = c;
      end
      if (fn == 6'h10) begin we = 1; d = ins[15:11]; v = ch; end
      if (fn == 6'h12) begin we = 1; d = ins[15:11]; v = cl; end
      if (fn == 6'h11) begin hwe = 1; hv = c; end
      if (fn == 6'h13) begin lwe = 1; lv = c; end
      if (fn inside {[6'h18:6'h1b]}) begin hwe = 1; hv = ih; lwe = 1; lv = il; end
      ovf = (fn == 6'h20 || fn == 6'h22) && zon[1];
    end else if (op inside {[6'h08:6'h0e]}) begin
      we = 1; d = ins[20:16]; v = c;
      ovf = (op == 6'h08) && zon[1];
    end
    if (ovf || d == 0) we = 0;
    if (!we) d = 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic we, hwe, lwe, ovf;
    logic [4:0] d;
    logic [31:0] v, hv, lv;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_gpr[i] <= '0;
      m_hi <= '0; m_lo <= '0; m_rv <= 0; m_we <= 0; m_rd <= '0; m_data <= '0; m_ovf <= 0;
    end else if (in_valid && m_ready) begin
      mdec(in_instr, in_c, in_zon, in_hi, in_lo, m_hi, m_lo, we, d, v, hwe, hv, lwe, lv, ovf);
      if (we)  m_gpr[d] <= v;
      if (hwe) m_hi <= hv;
      if (lwe) m_lo <= lv;
      m_rv <= 1; m_we <= we; m_rd <= d; m_data <= v; m_ovf <= ovf;
    end else if (ret_ready) begin
      m_rv <= 0;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic we, hwe, lwe, ovf;
    logic [4:0] d;
    logic [31:0] v, hv, lv;
    mdec(in_instr, in_c, in_zon, in_hi, in_lo, m_hi, m_lo, we, d, v, hwe, hv, lwe, lv, ovf);
    if (a == 0) return 0;
    if (in_valid && m_ready && we && d == a) return v;
    return m_gpr[a];
  endfunction

  // Single compare process, mid-cycle (inputs settle at negedge)
  always begin
    @(negedge clk);
    #2;
    if (cmp_en) begin
      chk("m_in_ready", in_ready, m_ready);
      chk("m_rs_data", rs_data, exp_rd(rs_addr));
      chk("m_rt_data", rt_data, exp_rd(rt_addr));
      chk("m_hi", hi_q, m_hi);
      chk("m_lo", lo_q, m_lo);
      chk("m_ret_valid", ret_valid, m_rv);
      chk("m_ret_we", ret_we, m_we);
      chk("m_ret_rd", ret_rd, m_rd);
      chk("m_ret_ovf", ret_ovf, m_ovf);
      if (m_we) chk("m_ret_data", ret_data, m_data);
    end
  end

  logic [5:0] rfn [26] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
                           6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h10, 6'h11,
                           6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h08, 6'h01};
  logic [5:0] iop [12] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e,
                           6'h23, 6'h2b, 6'h04, 6'h05, 6'h0f};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = int'($urandom_range(0, 9));
    if (k < 5) return {6'h00, r[25:6], rfn[$urandom_range(0, 25)]};
    if (k < 9) return {iop[$urandom_range(0, 11)], r[25:0]};
    return r;
  endfunction

  task automatic drv(input logic v, input logic [31:0] ins, c, input logic [2:0] z,
                     input logic [31:0] h, l);
    in_valid = v; in_instr = ins; in_c = c; in_zon = z; in_hi = h; in_lo = l;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_hi", hi_q, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    ret_ready = 1;
    // addu rd=3
    drv(1, 32'h00221821, 32'hC040403F, 3'b000, 0, 0); rt_addr = 3; rs_addr = 0;
    #3 chk("addu_bypass", rt_data, 32'hC040403F);
    @(negedge clk);
    // add rd=5 with overflow
    drv(1, 32'h00002820, 32'h7FFFFFFF, 3'b010, 0, 0); rs_addr = 5;
    #3;
    chk("addu_ret_valid", ret_valid, 1);
    chk("addu_ret_rd", ret_rd, 3);
    chk("addu_ret_data", ret_data, 32'hC040403F);
    chk("addu_rt3", rt_data, 32'hC040403F);
    chk("add_ovf_nobypass", rs_data, 0);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0);
    #3;
    chk("add_ret_ovf", ret_ovf, 1);
    chk("add_ret_we", ret_we, 0);
    chk("add_ret_rd", ret_rd, 0);
    chk("add_reg5", rs_data, 0);
    @(negedge clk);
    // addu rd=5 ignores the overflow flag
    drv(1, 32'h00002821, 32'h7FFFFFFF, 3'b010, 0, 0);
    @(negedge clk);
    // mult
    drv(1, 32'h00000018, 32'h0, 3'b000, 32'h3FFFFFF6, 32'h80000013);
    #3;
    chk("addu5_ret_ovf", ret_ovf, 0);
    chk("addu5_ret_we", ret_we, 1);
    chk("addu_reg5", rs_data, 32'h7FFFFFFF);
    @(negedge clk);
    // mflo rd=8
    drv(1, 32'h00004012, 32'h0, 3'b000, 0, 0); rs_addr = 8;
    #3;
    chk("mult_hi", hi_q, 32'h3FFFFFF6);
    chk("mult_lo", lo_q, 32'h80000013);
    chk("mflo_bypass", rs_data, 32'h80000013);
    @(negedge clk);
    // addi rt=0
    drv(1, 32'h20000000, 32'h00001234, 3'b000, 0, 0); rs_addr = 0;
    #3;
    chk("mflo_ret_rd", ret_rd, 8);
    chk("mflo_ret_data", ret_data, 32'h80000013);
    chk("r0_read", rs_data, 0);
    @(negedge clk);
    // ori rt=9
    drv(1, 32'h34090000, 32'hABCD5555, 3'b000, 0, 0); rs_addr = 9; rt_addr = 0;
    #3;
    chk("addi_r0_we", ret_we, 0);
    chk("addi_r0_rd", ret_rd, 0);
    chk("r0_after_addi", rt_data, 0);
    chk("ori_bypass", rs_data, 32'hABCD5555);
    @(negedge clk);
    // backpressure for three cycles
    ret_ready = 0;
    drv(1, 32'h340A0000, 32'h1, 3'b000, 0, 0); rs_addr = 10;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_ret_rd", ret_rd, 9);
      chk("stall_ret_data", ret_data, 32'hABCD5555);
      chk("stall_reg10", rs_data, 0);
      @(negedge clk);
    end
    ret_ready = 1;
    #3;
    chk("release_in_ready", in_ready, 1);
    chk("release_bypass", rs_data, 1);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0);
    #3;
    chk("release_ret_rd", ret_rd, 10);
    chk("release_ret_data", ret_data, 1);
    @(negedge clk);

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      drv($urandom_range(0, 3) != 0, rand_instr(), $urandom, 3'($urandom), $urandom, $urandom);
      ret_ready = $urandom_range(0, 9) < 7;
      rs_addr = 5'($urandom); rt_addr = 5'($urandom);
      @(negedge clk);
    end

    // Reset while a record is stalled
    drv(1, 32'h00000019, 32'h0, 3'b000, 32'h11112222, 32'h33334444); ret_ready = 1;
    @(negedge clk);
    drv(1, 32'h340B0000, 32'h5, 3'b000, 0, 0);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0); ret_ready = 0; rs_addr = 11;
    #3;
    chk("pre_rst_ret_valid", ret_valid, 1);
    chk("pre_rst_reg11", rs_data, 5);
    chk("pre_rst_hi", hi_q, 32'h11112222);
    rst_n = 0;
    #1;
    chk("rst_mid_ret_valid", ret_valid, 0);
    chk("rst_mid_hi", hi_q, 0);
    chk("rst_mid_lo", lo_q, 0);
    for (int i = 1; i < 32; i++) begin
      rs_addr = 5'(i);
      #1 chk("rst_mid_gpr", rs_data, 0);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_writeback_stage.md
Name: mips_writeback_stage

Overview:
- Retires each ALU result into the architectural state: 32x32 general register file plus HI/LO registers.
- Sits directly downstream of the ALU and consumes its instruction, c, zon, hi and lo.
- Its two read ports drive the ALU's gr1/gr2 operands for the next instruction.
- Uses a valid/ready handshake with a one-entry output register carrying a retire record.

Parameters:
- NREG, 32, number of general registers (register 0 hard-wired to zero)
- XLEN, 32, data width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  ALU result presented
- in_ready  out  1  stage can accept a result this cycle
- in_instr  in  32  instruction that produced the result
- in_c  in  32  ALU result
- in_zon  in  3  ALU flags: [2] zero, [1] overflow, [0] negative
- in_hi  in  32  ALU HI output
- in_lo  in  32  ALU LO output
- rs_addr  in  5  read port A address
- rs_data  out  32  read port A data (to gr1)
- rt_addr  in  5  read port B address
- rt_data  out  32  read port B data (to gr2)
- hi_q  out  32  architectural HI
- lo_q  out  32  architectural LO
- ret_valid  out  1  retire record valid
- ret_ready  in  1  retire consumer accepts
- ret_we  out  1  record wrote a GPR
- ret_rd  out  5  destination written (0 if none)
- ret_data  out  32  value written
- ret_ovf  out  1  record was a trapped overflow

Behaviour:
- Reset (async assert, sync release):
  - All GPRs, hi_q and lo_q clear to 0.
  - ret_valid, ret_we, ret_ovf clear to 0; ret_rd and ret_data clear to 0.
- Accept: in_ready = !ret_valid || ret_ready. A transfer occurs when in_valid && in_ready.
- On transfer, state updates and the retire record load at the same edge. Latency is one cycle to ret_valid.
- Decode, opcode = in_instr[31:26], func = in_instr[5:0]:
  - R-type writes rd = in_instr[15:11] with in_c for these funcs: 0x00, 02, 03, 04, 06, 07, 20, 21, 22, 23, 24, 25, 26, 27, 2a, 2b.
  - func 0x18/19/1a/1b (mult/multu/div/divu): HI <- in_hi, LO <- in_lo; no GPR write.
  - func 0x10 (mfhi) writes rd <- hi_q; func 0x12 (mflo) writes rd <- lo_q. Both read the current architectural HI/LO.
  - func 0x11 (mthi): HI <- in_c. func 0x13 (mtlo): LO <- in_c.
  - I-type opcodes 0x08, 09, 0a, 0b, 0c, 0d, 0e write rt = in_instr[20:16] with in_c.
  - lw (0x23), sw (0x2b), beq (0x04), bne (0x05) and any unlisted encoding: no state change. The record retires with ret_we = 0.
- Overflow trap for add (R 0x20), sub (R 0x22) and addi (0x08) when in_zon[1] = 1:
  - The GPR write is suppressed.
  - ret_ovf = 1, ret_we = 0, ret_rd = 0.
  - addu/subu/addiu ignore in_zon[1].
- Destination 0 is never written; ret_we = 0 and ret_rd = 0 in that case.
- Read ports are combinational with write-first bypass. If a transfer this cycle writes register r and rs_addr or rt_addr equals r (r != 0), that port returns the value being written. Address 0 returns 0.
- Backpressure: while ret_valid && !ret_ready, in_ready = 0, no state changes, and the record holds stable.
- A simultaneous accept and ret_ready replaces the record in the same cycle.
- Reset mid-stall discards the pending record.

Optional Feature:
- Macro WB_STATS_EN.
- When defined, add outputs stat_retired[31:0] and stat_ovf[15:0]:
  - stat_retired increments on every transfer and wraps at 2^32.
  - stat_ovf increments on each trapped overflow and saturates at 0xFFFF.
  - Both clear on reset.
- When undefined, neither port nor counter exists and the stage behaves identically otherwise.

Test Plan:
- addu instr 0x00221821 (rd=3), in_c=0xC040403F, in_valid=1, ret_ready=1 -> next cycle ret_valid=1, ret_rd=3, ret_data=0xC040403F; rt_addr=3 returns 0xC040403F.
- add rd=5, in_c=0x7FFFFFFF, in_zon=3'b010 -> ret_ovf=1, ret_we=0, reg5 stays 0. Same with addu -> reg5=0x7FFFFFFF.
- mult (func 0x18), in_hi=0x3FFFFFF6, in_lo=0x80000013; then mflo rd=8 -> hi_q=0x3FFFFFF6, reg8=0x80000013.
- addi rt=0 with in_c=0x1234 -> register 0 reads 0, ret_we=0. Same cycle, ori rt=9 with rs_addr=9 -> bypass shows the new value before the edge.
- Hold ret_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, record and registers frozen; release -> next result accepted.
- rst_n low while ret_valid=1 -> ret_valid=0 immediately; all GPRs and HI/LO read 0.
